pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. Sits beside the `instruction_fetch_top`, `instruction_decode_top` and `execution_top` stages and generates every pipeline-register enable, flush and bubble. It keeps a registered scoreboard of in-flight destination registers to detect RAW hazards and selects operand forwarding. It also squashes wrong-path instructions after a taken branch or jump, and freezes the whole pipe while data memory is not ready.

## Interface
- `CNT_W`, 16, width of the stall-cycle counter.
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_id_valid`  in  1  ID stage holds a real instruction.
- `i_id_rs`, `i_id_rt`  in  5  source register numbers of the ID instruction.
- `i_id_uses_rs`, `i_id_uses_rt`  in  1  ID instruction reads that source.
- `i_id_dest`  in  5  destination register number (after RT/RD mux).
- `i_id_writes`  in  1  ID instruction writes the register file.
- `i_id_is_load`  in  1  ID instruction is a load.
- `i_ex_taken`  in  1  branch or jump resolved taken in EX this cycle.
- `i_mem_ready`  in  1  data memory can complete this cycle.
- `o_pc_en`, `o_ifid_en`, `o_idex_en`, `o_exmem_en`, `o_memwb_en`  out  1  stage-register enables.
- `o_ifid_flush`  out  1  load NOP into IF/ID.
- `o_idex_bubble`  out  1  load NOP (all control zero) into ID/EX.
- `o_fwd_a`, `o_fwd_b`  out  2  forward select for rs/rt, captured into ID/EX: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- `o_action`  out  2  current-cycle action: 00 RUN, 01 STALL, 10 FLUSH, 11 FREEZE.
- `o_stall_cycles`  out  `CNT_W`  saturating count of STALL cycles.

## Operation
- Scoreboard: three registered slots EX, MEM, WB, each holding {valid, dest, writes, is_load}.
- A slot matches a source when it is valid, writes, has a nonzero dest equal to the source, and the corresponding `uses` bit is set. Register 0 never matches.
- Actions are evaluated combinationally each cycle, in strict priority order:
  - **FREEZE** when `i_mem_ready`=0. All enables are 0, no flush or bubble, and the scoreboard and counter hold.
  - **FLUSH** when `i_ex_taken`=1. `o_pc_en`=1 (PC takes the target) and `o_ifid_flush`=1. `o_idex_bubble`=1 squashes the ID instruction. All other enables are 1.
  - **STALL** on a hazard, with `i_id_valid`=1. `o_pc_en`=0, `o_ifid_en`=0, `o_idex_bubble`=1, downstream enables are 1, and the counter increments (saturating at all-ones).
  - **RUN** otherwise. All enables are 1 and there are no flushes.
- Scoreboard advance, whenever the action is not FREEZE: WB←MEM, MEM←EX, EX←ID fields. EX.valid is `i_id_valid & ~o_idex_bubble`.
- `o_fwd_a`/`o_fwd_b` are computed for the ID instruction:
  - EX-slot match gives 10. EX has priority, being the youngest.
  - Otherwise a MEM-slot match gives 01.
  - Otherwise 00.
- When the action is not RUN, `o_fwd_*` are 00.

## Timing
- Reset values: scoreboard slots invalid, counter 0.
- While reset is asserted, outputs are driven from the invalid scoreboard: all enables 1, flush/bubble 0, `o_fwd_*`=00, `o_action` RUN unless FREEZE or FLUSH inputs are active.
- Reset asserted mid-stall clears the scoreboard asynchronously, so the STALL condition drops in the same cycle.
- Load-use (forwarding on): load in EX with a matching source gives exactly 1 STALL cycle. In the next cycle the load is in MEM and forwarding gives 01.
- A taken branch coinciding with a hazard resolves as FLUSH: the dependent instruction is squashed and no stall is counted.
- FREEZE coinciding with a taken branch: FREEZE wins. `i_ex_taken` must be held by the EX stage until the first non-frozen cycle.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - The hazard condition is load-use only, i.e. an EX-slot match with is_load.
  - Forwarding selects operate as above.
- `HAZARD_FORWARDING_EN` undefined:
  - The hazard condition is any match in the EX, MEM or WB slot.
  - `o_fwd_a`/`o_fwd_b` are tied to 00.
  - A back-to-back ALU dependency costs 3 STALL cycles.

## Structure
- The shared package `pipeline_pkg` holds:
  - The `o_action` encodings: ACT_RUN, ACT_STALL, ACT_FLUSH, ACT_FREEZE.
  - The forward encodings: FWD_RF, FWD_EXMEM, FWD_MEMWB.
  - The scoreboard slot struct.
- One natural sub-module, `hazard_scoreboard`, holds the three-slot shift register and match logic. The priority and forwarding logic stays in the top.

## Test plan
- With forwarding, `lw $2` followed by `add $3,$2,$4` → 1 cycle of STALL (PC/IF/ID held, bubble into ID/EX), then `o_fwd_a`=01; counter=1.
- With forwarding, `add $2` followed by `sub $5,$4,$2` → no stall, `o_fwd_b`=10. Without forwarding → 3 STALL cycles, counter=3.
- A dependency on `$0` (writer dest 0) → never stalls, fwd=00.
- `i_ex_taken`=1 with the ID instruction hazarded → FLUSH only: `o_ifid_flush`=1, `o_idex_bubble`=1, counter unchanged, EX slot invalid next cycle.
- `i_mem_ready`=0 for 4 cycles during a load-use stall → FREEZE for 4 cycles with the scoreboard held, then exactly 1 STALL.
- Reset asserted during a STALL → all slots invalid, counter 0, action RUN immediately. Saturation: preload the counter at 0xFFFF, then a stall → it remains 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared encodings, scoreboard slot type and slot match helper (package pipeline_pkg).
package pipeline_pkg;
   typedef enum logic [1:0] {
      ACT_RUN    = 2'b00,
      ACT_STALL  = 2'b01,
      ACT_FLUSH  = 2'b10,
      ACT_FREEZE = 2'b11
   } action_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       writes;
      logic       is_load;
   } slot_t;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   function automatic logic slot_hit(slot_t s, logic [4:0] r, logic u);
      return u & s.valid & s.writes & (s.dest != 5'd0) & (s.dest == r);
   endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundle between the pipeline stages (master) and the hazard controller (slave).
//   i_id_*      ID-stage instruction description
//   i_ex_taken  branch/jump taken in EX
//   i_mem_ready data memory completes this cycle
//   o_*_en      stage register enables; o_ifid_flush / o_idex_bubble NOP inserts
//   o_fwd_a/b   forward selects; o_action current action; o_stall_cycles stall counter
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
   logic             i_id_valid;
   logic [4:0]       i_id_rs;
   logic [4:0]       i_id_rt;
   logic             i_id_uses_rs;
   logic             i_id_uses_rt;
   logic [4:0]       i_id_dest;
   logic             i_id_writes;
   logic             i_id_is_load;
   logic             i_ex_taken;
   logic             i_mem_ready;
   logic             o_pc_en;
   logic             o_ifid_en;
   logic             o_idex_en;
   logic             o_exmem_en;
   logic             o_memwb_en;
   logic             o_ifid_flush;
   logic             o_idex_bubble;
   logic [1:0]       o_fwd_a;
   logic [1:0]       o_fwd_b;
   logic [1:0]       o_action;
   logic [CNT_W-1:0] o_stall_cycles;

   modport master (
      output i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_dest,
             i_id_writes, i_id_is_load, i_ex_taken, i_mem_ready,
      input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_ifid_flush,
             o_idex_bubble, o_fwd_a, o_fwd_b, o_action, o_stall_cycles
   );

   modport slave (
      input  i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_dest,
             i_id_writes, i_id_is_load, i_ex_taken, i_mem_ready,
      output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_ifid_flush,
             o_idex_bubble, o_fwd_a, o_fwd_b, o_action, o_stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB in-flight destination slots and source match flags.
//   clk, rst_n      clock, async active-low reset
//   adv             shift the slots one stage
//   id              slot entering EX
//   rs/rt, use_*    ID sources and their use bits
//   hit_a/hit_b     per-slot match {wb, mem, ex}; ex_load EX slot holds a load
module hazard_scoreboard
   import pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   input  slot_t      id,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       use_rs,
   input  logic       use_rt,
   output logic [2:0] hit_a,
   output logic [2:0] hit_b,
   output logic       ex_load
);
   slot_t ex, mem, wb;
   logic  unused_wb;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ex  <= '0;
         mem <= '0;
         wb  <= '0;
      end else if (adv) begin
         wb  <= mem;
         mem <= ex;
         ex  <= id;
      end

   assign hit_a     = {slot_hit(wb, rs, use_rs), slot_hit(mem, rs, use_rs), slot_hit(ex, rs, use_rs)};
   assign hit_b     = {slot_hit(wb, rt, use_rt), slot_hit(mem, rt, use_rt), slot_hit(ex, rt, use_rt)};
   assign ex_load   = ex.is_load;
   assign unused_wb = wb.is_load;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: MIPS pipeline hazard/sequencing controller (enables, flush, bubble, forwarding).
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      pipeline_hazard_ctrl_if.slave carrying all ID/EX/MEM inputs and control outputs
// Macro HAZARD_FORWARDING_EN: defined -> load-use stalls only plus forwarding;
// undefined -> stall on any in-flight match, forward selects tied to regfile.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic             i_clk,
   input logic             i_reset,
   pipeline_hazard_ctrl_if.slave bus
);
   logic [2:0]       hit_a, hit_b;
   logic             ex_load, hazard, bubble, unused_sb;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] cnt;
   action_t          act;
   slot_t            id_slot;

   assign id_slot = '{valid: bus.i_id_valid & ~bubble, dest: bus.i_id_dest,
                      writes: bus.i_id_writes, is_load: bus.i_id_is_load};

   hazard_scoreboard u_sb (
      .clk    (i_clk),
      .rst_n  (i_reset),
      .adv    (act != ACT_FREEZE),
      .id     (id_slot),
      .rs     (bus.i_id_rs),
      .rt     (bus.i_id_rt),
      .use_rs (bus.i_id_uses_rs),
      .use_rt (bus.i_id_uses_rt),
      .hit_a  (hit_a),
      .hit_b  (hit_b),
      .ex_load(ex_load)
   );

`ifdef HAZARD_FORWARDING_EN
   assign hazard = ex_load & (hit_a[0] | hit_b[0]);
   // EX is the youngest producer, so it wins over MEM.
   assign fwd_a  = hit_a[0] ? FWD_EXMEM : hit_a[1] ? FWD_MEMWB : FWD_RF;
   assign fwd_b  = hit_b[0] ? FWD_EXMEM : hit_b[1] ? FWD_MEMWB : FWD_RF;
`else
   assign hazard = |{hit_a, hit_b};
   assign fwd_a  = FWD_RF;
   assign fwd_b  = FWD_RF;
`endif
   assign unused_sb = ^{hit_a[2], hit_b[2], ex_load};

   assign act = !bus.i_mem_ready ? ACT_FREEZE :
                bus.i_ex_taken ? ACT_FLUSH :
                (bus.i_id_valid & hazard) ? ACT_STALL : ACT_RUN;

   assign bubble            = act == ACT_FLUSH || act == ACT_STALL;
   assign bus.o_pc_en       = act == ACT_RUN || act == ACT_FLUSH;
   assign bus.o_ifid_en     = act == ACT_RUN || act == ACT_FLUSH;
   assign bus.o_idex_en     = act != ACT_FREEZE;
   assign bus.o_exmem_en    = act != ACT_FREEZE;
   assign bus.o_memwb_en    = act != ACT_FREEZE;
   assign bus.o_ifid_flush  = act == ACT_FLUSH;
   assign bus.o_idex_bubble = bubble;
   assign bus.o_fwd_a       = act == ACT_RUN ? fwd_a : FWD_RF;
   assign bus.o_fwd_b       = act == ACT_RUN ? fwd_b : FWD_RF;
   assign bus.o_action      = act;
   assign bus.o_stall_cycles = cnt;

   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) cnt <= '0;
      else if (act == ACT_STALL && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench; driver queues expected responses, monitor compares each cycle.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   typedef struct packed {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] d;
      logic       wr, ld;
   } ins_t;

   typedef struct packed {
      logic [1:0]  a, fa, fb;
      logic [15:0] c;
      logic [3:0]  s;
   } exp_t;

   localparam ins_t NOP  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
   localparam ins_t LW2  = '{1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1};
   localparam ins_t ADD3 = '{1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0};
   localparam ins_t ADD2 = '{1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0};
   localparam ins_t SUB5 = '{1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0};
   localparam ins_t LW0  = '{1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};
   localparam ins_t USE0 = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0};
   localparam ins_t LW3  = '{1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1};
   localparam ins_t USE3 = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0};

`ifdef HAZARD_FORWARDING_EN
   localparam int NST = 1;
   localparam int NALU = 0;
   localparam logic [1:0] F_EX = FWD_EXMEM;
   localparam logic [1:0] F_MEM = FWD_MEMWB;
`else
   localparam int NST = 3;
   localparam int NALU = 3;
   localparam logic [1:0] F_EX = FWD_RF;
   localparam logic [1:0] F_MEM = FWD_RF;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   ins_t        cur = NOP;
   logic        tk = 1'b0;
   logic        rdy = 1'b1;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] mcnt = '0;
   logic [3:0]  mscnt = '0;
   event        probe;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) hif();
   pipeline_hazard_ctrl_if #(.CNT_W(4))  sif();

   pipeline_hazard_ctrl #(.CNT_W(16)) dut     (.i_clk(i_clk), .i_reset(i_reset), .bus(hif.slave));
   pipeline_hazard_ctrl #(.CNT_W(4))  dut_sat (.i_clk(i_clk), .i_reset(i_reset), .bus(sif.slave));

   assign {hif.i_id_valid, hif.i_id_rs, hif.i_id_rt, hif.i_id_uses_rs, hif.i_id_uses_rt,
           hif.i_id_dest, hif.i_id_writes, hif.i_id_is_load, hif.i_ex_taken, hif.i_mem_ready} = {cur, tk, rdy};
   assign {sif.i_id_valid, sif.i_id_rs, sif.i_id_rt, sif.i_id_uses_rs, sif.i_id_uses_rt,
           sif.i_id_dest, sif.i_id_writes, sif.i_id_is_load, sif.i_ex_taken, sif.i_mem_ready} = {cur, tk, rdy};

   always #5 i_clk = ~i_clk;

   function automatic logic [6:0] ctl_of(input logic [1:0] a);
      case (a)
         ACT_RUN:   return 7'b1111100;
         ACT_STALL: return 7'b0011101;
         ACT_FLUSH: return 7'b1111111;
         default:   return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] ea, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e = '{ea, fa, fb, mcnt, mscnt};
      q.push_back(e);
      if (ea == ACT_STALL) begin
         if (mcnt != 16'hffff) mcnt++;
         if (mscnt != 4'hf) mscnt++;
      end
   endtask

   task automatic step(input ins_t i, input logic t, input logic r,
                       input logic [1:0] ea, input logic [1:0] fa, input logic [1:0] fb);
      @(posedge i_clk);
      #1;
      cur = i;
      tk  = t;
      rdy = r;
      push(ea, fa, fb);
   endtask

   task automatic drain();
      repeat (3) step(NOP, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk or probe);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("action", hif.o_action, e.a);
            chk("ctl", {hif.o_pc_en, hif.o_ifid_en, hif.o_idex_en, hif.o_exmem_en, hif.o_memwb_en,
                        hif.o_ifid_flush, hif.o_idex_bubble}, ctl_of(e.a));
            chk("fwd_a", hif.o_fwd_a, e.fa);
            chk("fwd_b", hif.o_fwd_b, e.fb);
            chk("stall_cycles", hif.o_stall_cycles, e.c);
            chk("sat_cycles", sif.o_stall_cycles, e.s);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      step(NOP, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      step(NOP, 1'b1, 1'b1, ACT_FLUSH, FWD_RF, FWD_RF);
      step(NOP, 1'b0, 1'b0, ACT_FREEZE, FWD_RF, FWD_RF);
      i_reset = 1'b1;
      // load-use
      step(LW2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      repeat (NST) step(ADD3, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
      step(ADD3, 1'b0, 1'b1, ACT_RUN, F_MEM, FWD_RF);
      drain();
      // back-to-back ALU dependency
      step(ADD2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      repeat (NALU) step(SUB5, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
      step(SUB5, 1'b0, 1'b1, ACT_RUN, FWD_RF, F_EX);
      drain();
      // EX and MEM both produce $2: EX wins
      step(ADD2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      step(ADD2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      repeat (NALU) step(SUB5, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
      step(SUB5, 1'b0, 1'b1, ACT_RUN, FWD_RF, F_EX);
      drain();
      // $0 never matches
      step(LW0, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      step(USE0, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      drain();
      // taken branch over a hazard, squashed load must not linger in EX
      step(LW2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      step(LW3, 1'b1, 1'b1, ACT_FLUSH, FWD_RF, FWD_RF);
      step(USE3, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      drain();
      step(NOP, 1'b1, 1'b0, ACT_FREEZE, FWD_RF, FWD_RF);
      step(NOP, 1'b1, 1'b1, ACT_FLUSH, FWD_RF, FWD_RF);
      drain();
      // freeze during a load-use stall
      step(LW2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      repeat (4) step(ADD3, 1'b0, 1'b0, ACT_FREEZE, FWD_RF, FWD_RF);
      repeat (NST) step(ADD3, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
      step(ADD3, 1'b0, 1'b1, ACT_RUN, F_MEM, FWD_RF);
      drain();
      // reset asserted in the middle of a stall cycle
      step(LW2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      step(ADD3, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
      @(negedge i_clk);
      #2;
      i_reset = 1'b0;
      mcnt = '0;
      mscnt = '0;
      #1;
      push(ACT_RUN, FWD_RF, FWD_RF);
      ->probe;
      step(ADD3, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      i_reset = 1'b1;
      step(ADD3, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
      drain();
      // 18 stalls: 16-bit counter reaches 18, 4-bit counter sticks at 15
      repeat (18 / NST) begin
         step(LW2, 1'b0, 1'b1, ACT_RUN, FWD_RF, FWD_RF);
         repeat (NST) step(ADD3, 1'b0, 1'b1, ACT_STALL, FWD_RF, FWD_RF);
         step(ADD3, 1'b0, 1'b1, ACT_RUN, F_MEM, FWD_RF);
      end
      drain();
      repeat (3) @(negedge i_clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
